serial_alu_sequencer: RTL
=========================

Name: serial_alu_sequencer

Overview:
- Bit-serial driver for a single combinational ALU bit slice; produces the slice's inputs (a, b, select, carry-in, SLT chain inputs, first flag) one bit per cycle and collects its outputs.
- Accepts a WIDTH-bit operation over a valid/ready handshake and returns the assembled result over a second valid/ready handshake.
- Sits between instruction control and one external bit slice instance; trades WIDTH cycles of latency for one slice of area.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous reset, active low
- op_valid  input  1  operation request valid
- op_ready  output  1  sequencer can accept an operation
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- op_sel  input  3  0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR
- slice_a  output  1  current A bit to slice
- slice_b  output  1  current B bit to slice (inverted for SUB)
- slice_s  output  3  latched op_sel to slice
- slice_carry_in  output  1  carry into slice
- slice_k_in  output  1  SLT "all more significant bits equal" in
- slice_ans_in  output  1  SLT answer-so-far in
- slice_first  output  1  high while driving bit WIDTH-1 in SLT (sign bit)
- slice_out  input  1  slice result bit
- slice_carry_out  input  1  slice carry out
- slice_k_out  input  1  slice SLT equal-so-far out
- slice_ans_out  input  1  slice SLT answer out
- res_valid  output  1  result valid
- res_ready  input  1  consumer accepts result
- result  output  WIDTH  assembled result
- carryout  output  1  final carry of ADD/SUB, 0 otherwise
- zero  output  1  result == 0

Behaviour:
- Single clock, synchronous active-low reset; all state changes on rising clk.
- States IDLE, RUN, DONE. Reset -> IDLE; result=0, carryout=0, zero=0, res_valid=0, op_ready=1, bit index=0, carry/k/ans regs cleared, all slice_* outputs 0.
- IDLE: op_ready=1. op_valid&&op_ready latches op_a, op_b, op_sel; -> RUN. Carry reg := 1 if SUB else 0; k reg := 1; ans reg := 0; index := 0 (ADD/SUB/logic) or WIDTH-1 (SLT).
- RUN: op_ready=0. Drives slice_a=A[idx], slice_b=B[idx] (^1 when SUB), slice_s=sel, slice_carry_in=carry reg, slice_k_in=k reg, slice_ans_in=ans reg, slice_first=(sel==SLT && idx==WIDTH-1). Each cycle: result[idx] := slice_out (non-SLT); carry reg := slice_carry_out; k reg := slice_k_out; ans reg := slice_ans_out.
- Index order: LSB->MSB for all ops except SLT, which runs MSB->LSB. Exactly WIDTH RUN cycles.
- Last RUN cycle -> DONE. SLT: result := {WIDTH-1 zeros, slice_ans_out}. carryout := last slice_carry_out for ADD/SUB, 0 otherwise. zero computed from final result.
- Latency: accept at edge N, res_valid high from edge N+WIDTH+1.
- DONE: res_valid=1; result/carryout/zero held stable until res_valid&&res_ready, then -> IDLE. op_ready=0 in DONE (no overlap).
- slice_* outputs driven combinationally from registers; all 0 outside RUN.
- op_valid ignored when op_ready=0; operand inputs may change after acceptance.
- Reset asserted in any state aborts operation, restores reset values next edge; no partial result emitted.

Optional Feature:
- SERIAL_ALU_OVERFLOW_EN: adds output port overflow (1 bit). Defined: overflow := carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 for ADD/SUB, 0 for other ops, valid with res_valid, reset 0. Undefined: port absent, no extra state.

Test Plan:
- WIDTH=8, reset then ADD 0x7F+0x01, res_ready=1 -> res_valid 9 cycles after accept, result 0x80, carryout 0, zero 0 (overflow 1 if enabled).
- SUB 0x05-0x05 -> result 0x00, carryout 1, zero 1; first RUN cycle slice_carry_in=1, slice_b=~B[0].
- SLT 0xFF vs 0x01 (signed -1<1) -> result 0x01; slice_first high only on first RUN cycle, index 7 driven first. SLT 0x01 vs 0x01 -> result 0x00.
- NOR 0xF0,0x0C -> 0x03; hold res_ready=0 for 5 cycles -> result stable, op_ready=0, new op_valid ignored; res_ready=1 -> IDLE next cycle.
- Reset pulsed mid-RUN of ADD (cycle 4) -> next edge IDLE, op_ready=1, res_valid=0, result=0; following ADD 0x03+0x04 -> 0x07.
- Back-to-back: op_valid held high with res_ready=1 -> second op accepted the cycle after DONE handshake, results correct in order.

Source files
------------

// File: rtl/serial_alu_sequencer.sv
// Bit-serial sequencer that drives one external combinational ALU bit slice for WIDTH cycles.
// Optional overflow output is compiled in with `define SERIAL_ALU_OVERFLOW_EN.
module serial_alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       op_sel,
  output logic             slice_a,
  output logic             slice_b,
  output logic [2:0]       slice_s,
  output logic             slice_carry_in,
  output logic             slice_k_in,
  output logic             slice_ans_in,
  output logic             slice_first,
  input  logic             slice_out,
  input  logic             slice_carry_out,
  input  logic             slice_k_out,
  input  logic             slice_ans_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
`ifdef SERIAL_ALU_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             zero
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [2:0]    OP_ADD  = 3'd0;
  localparam logic [2:0]    OP_SUB  = 3'd1;
  localparam logic [2:0]    OP_SLT  = 3'd3;
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [2:0]       sel_q;
  logic [IW-1:0]    idx;
  logic             carry_q, k_q, ans_q, cout_q, zero_q, vld_q;
  logic             is_slt, is_arith, last;
`ifdef SERIAL_ALU_OVERFLOW_EN
  logic             ovf_q;
`endif

  assign is_slt   = (sel_q == OP_SLT);
  assign is_arith = (sel_q == OP_ADD) || (sel_q == OP_SUB);
  // SLT walks MSB->LSB so the sign bit is compared first; everything else ripples LSB->MSB.
  assign last     = is_slt ? (idx == '0) : (idx == IDX_TOP);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (op_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (vld_q && res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    slice_a        = 1'b0;
    slice_b        = 1'b0;
    slice_s        = 3'd0;
    slice_carry_in = 1'b0;
    slice_k_in     = 1'b0;
    slice_ans_in   = 1'b0;
    slice_first    = 1'b0;
    if (state == RUN) begin
      slice_a        = a_q[idx];
      slice_b        = b_q[idx] ^ (sel_q == OP_SUB);
      slice_s        = sel_q;
      slice_carry_in = carry_q;
      slice_k_in     = k_q;
      slice_ans_in   = ans_q;
      slice_first    = is_slt && (idx == IDX_TOP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 3'd0;
      idx     <= '0;
      carry_q <= 1'b0;
      k_q     <= 1'b0;
      ans_q   <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      vld_q   <= 1'b0;
`ifdef SERIAL_ALU_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (op_valid) begin
          a_q     <= op_a;
          b_q     <= op_b;
          sel_q   <= op_sel;
          carry_q <= (op_sel == OP_SUB);
          k_q     <= 1'b1;
          ans_q   <= 1'b0;
          idx     <= (op_sel == OP_SLT) ? IDX_TOP : '0;
        end
        RUN: begin
          carry_q <= slice_carry_out;
          k_q     <= slice_k_out;
          ans_q   <= slice_ans_out;
          if (!is_slt) res_q[idx] <= slice_out;
          if (last) begin
            if (is_slt) res_q <= {{(WIDTH-1){1'b0}}, slice_ans_out};
            cout_q <= is_arith && slice_carry_out;
`ifdef SERIAL_ALU_OVERFLOW_EN
            // carry_q is the carry into the MSB on the final ADD/SUB cycle
            ovf_q  <= is_arith && (carry_q ^ slice_carry_out);
`endif
          end else begin
            idx <= is_slt ? idx - IW'(1) : idx + IW'(1);
          end
        end
        DONE: begin
          // first DONE cycle settles zero from the completed result, then presents it
          if (!vld_q) begin
            vld_q  <= 1'b1;
            zero_q <= (res_q == '0);
          end else if (res_ready) begin
            vld_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign op_ready  = (state == IDLE);
  assign res_valid = vld_q;
  assign result    = res_q;
  assign carryout  = cout_q;
  assign zero      = zero_q;
`ifdef SERIAL_ALU_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule
